// File: rtl/ibus_mem_responder_if.sv
// Instruction-bus interface between a fetching core (master) and the
// memory responder (slave): command channel plus one-cycle response strobe.
interface ibus_mem_responder_if;
    logic        iBus_cmd_valid;
    logic        iBus_cmd_ready;
    logic [31:0] iBus_cmd_payload_pc;
    logic        iBus_rsp_ready;
    logic        iBus_rsp_err;
    logic [31:0] iBus_rsp_inst;

    modport master (
        output iBus_cmd_valid,
        output iBus_cmd_payload_pc,
        input  iBus_cmd_ready,
        input  iBus_rsp_ready,
        input  iBus_rsp_err,
        input  iBus_rsp_inst
    );

    modport slave (
        input  iBus_cmd_valid,
        input  iBus_cmd_payload_pc,
        output iBus_cmd_ready,
        output iBus_rsp_ready,
        output iBus_rsp_err,
        output iBus_rsp_inst
    );
endinterface

// File: rtl/ibus_mem_responder.sv
// Instruction memory responder for a fetch bus.
// Commands are accepted when valid && ready; each accepted fetch is answered
// exactly LATENCY cycles later, in order, with a one-cycle response strobe.
// At most MAX_OUTSTANDING fetches may be awaiting a response; a response
// cycle always frees a slot, so ready stays high in response cycles.
// A separate load port writes words into the array (read-before-write).
// Optional feature: define IBUS_MEM_RESPONDER_ERR_EN to answer misaligned or
// out-of-range fetches with an error response instead of wrapping the address.
module ibus_mem_responder #(
    parameter int DEPTH_WORDS     = 1024,
    parameter int LATENCY         = 1,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                       clk,
    input  logic                       rstf,
    ibus_mem_responder_if.slave        iBus,
    input  logic                       ld_en,
    input  logic [31:0]                ld_addr,
    input  logic [31:0]                ld_data
);
    localparam int ADDR_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // One in-flight fetch; data is captured at acceptance and simply delayed.
    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] inst;
    } slot_t;

    logic [31:0]      mem [DEPTH_WORDS];
    slot_t            pipe [LATENCY];
    logic [CNT_W-1:0] outstanding;
    logic             accept;
    logic             rsp_fire;
    logic             addr_err;
    logic [ADDR_W-1:0] fetch_idx;
    logic [ADDR_W-1:0] load_idx;
    logic             unused_bits;

    assign fetch_idx = iBus.iBus_cmd_payload_pc[ADDR_W+1:2];
    assign load_idx  = ld_addr[ADDR_W-1:0];

`ifdef IBUS_MEM_RESPONDER_ERR_EN
    assign addr_err = (iBus.iBus_cmd_payload_pc[1:0] != 2'b00) ||
                      (iBus.iBus_cmd_payload_pc[31:2] >= 30'(DEPTH_WORDS));
`else
    assign addr_err = 1'b0;
`endif

    // Address bits above the array size (and the byte offset) only matter
    // when error reporting is enabled; otherwise the address wraps.
    assign unused_bits = ^{iBus.iBus_cmd_payload_pc[31:ADDR_W+2],
                           iBus.iBus_cmd_payload_pc[1:0],
                           ld_addr[31:ADDR_W]};

    // The last slot of the pipe is the registered response of this cycle.
    assign rsp_fire = pipe[LATENCY-1].valid;

    // Ready depends only on registered state (and reset), never on cmd_valid.
    assign iBus.iBus_cmd_ready = !rstf && ((outstanding < MAX_CNT) || rsp_fire);
    assign accept              = iBus.iBus_cmd_valid && iBus.iBus_cmd_ready;

    // Responses are blanked while reset is held so a strobe can never leak
    // out for a fetch accepted before the reset.
    assign iBus.iBus_rsp_ready = rsp_fire && !rstf;
    assign iBus.iBus_rsp_err   = pipe[LATENCY-1].err && !rstf;
    assign iBus.iBus_rsp_inst  = rstf ? 32'h0 : pipe[LATENCY-1].inst;

    // Load-port writes into the instruction array.
    // NOTE: the storage array has no reset; its contents survive rstf and only
    // the loader changes them, so no reset branch is written for it.
    always_ff @(posedge clk) begin
        if (ld_en && !rstf) begin
            mem[load_idx] <= ld_data;
        end
    end

    // Fetch pipeline: read at acceptance, then delay LATENCY-1 more cycles.
    // NOTE: non-blocking assignments everywhere in clocked logic; the array
    // read here therefore sees the value from before a same-edge load write,
    // which is exactly the read-before-write behaviour the bus expects.
    always_ff @(posedge clk) begin
        if (rstf) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            if (accept) begin
                pipe[0].valid <= 1'b1;
                pipe[0].err   <= addr_err;
                pipe[0].inst  <= addr_err ? 32'h0 : mem[fetch_idx];
            end else begin
                pipe[0] <= '0;
            end
            for (int i = 1; i < LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // Outstanding-fetch counter: +1 on accept, -1 after a response cycle.
    always_ff @(posedge clk) begin
        if (rstf) begin
            outstanding <= '0;
        end else if (accept && !rsp_fire) begin
            outstanding <= outstanding + CNT_ONE;
        end else if (!accept && rsp_fire) begin
            outstanding <= outstanding - CNT_ONE;
        end
    end
endmodule

// File: doc/ibus_mem_responder.md
IBUS_MEM_RESPONDER -- requirements
Module: ibus_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit instruction words stored (power of 2, 16..65536).
REQ-002 SHALL have parameter LATENCY, default 1: cycles from command acceptance to response (1..4).
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 2: maximum accepted commands without a response (1..8).
REQ-004 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rstf  input  1  synchronous, active-high reset.
REQ-006 SHALL have port iBus_cmd_valid  input  1  the core presents a fetch request.
REQ-007 SHALL have port iBus_cmd_ready  output  1  the responder accepts the request this cycle.
REQ-008 SHALL have port iBus_cmd_payload_pc  input  32  byte address of the fetch.
REQ-009 SHALL have port iBus_rsp_ready  output  1  one-cycle strobe marking a valid response.
REQ-010 SHALL have port iBus_rsp_err  output  1  the response is an error; qualified by iBus_rsp_ready.
REQ-011 SHALL have port iBus_rsp_inst  output  32  fetched instruction word; qualified by iBus_rsp_ready.
REQ-012 SHALL have port ld_en  input  1  memory load write strobe.
REQ-013 SHALL have port ld_addr  input  32  word index for the load write.
REQ-014 SHALL have port ld_data  input  32  word written on ld_en.

Function
REQ-015 SHALL accept a command in any cycle where iBus_cmd_valid and iBus_cmd_ready are both 1.
REQ-016 SHALL drive iBus_cmd_ready = (outstanding < MAX_OUTSTANDING) OR iBus_rsp_ready, from registered state only, with no path from iBus_cmd_valid.
REQ-017 SHALL present the response to a command accepted in cycle T in cycle T+LATENCY exactly, as registered outputs.
REQ-018 SHALL return responses in acceptance order, one per accepted command, with no response backpressure.
REQ-019 SHALL drive iBus_rsp_ready high for exactly one cycle per response, and low otherwise.
REQ-020 SHALL set outstanding +1 on acceptance and -1 at the end of each response cycle; if both happen in one cycle, it is unchanged.
REQ-021 SHALL sustain one command per cycle when MAX_OUTSTANDING >= LATENCY.
REQ-022 SHALL read memory word pc[31:2] mod DEPTH_WORDS and return it on iBus_rsp_inst with iBus_rsp_err=0.
REQ-023 SHALL drive iBus_rsp_inst and iBus_rsp_err to 0 in cycles with iBus_rsp_ready=0.
REQ-024 SHALL write ld_data to word ld_addr mod DEPTH_WORDS on ld_en.
REQ-025 SHALL return the old word when a load write and a fetch hit the same word in the same cycle (read-before-write).

Reset
REQ-026 SHALL, while rstf=1, clear outstanding to 0, invalidate every in-flight pipeline slot, and force iBus_cmd_ready=0, iBus_rsp_ready=0, iBus_rsp_err=0 and iBus_rsp_inst=0.
REQ-027 SHALL never emit a response for a command accepted before a reset asserted mid-operation.
REQ-028 SHALL leave memory contents unchanged by reset, and SHALL ignore ld_en while rstf=1.
REQ-029 SHALL raise iBus_cmd_ready in the first cycle after rstf deasserts.

Configuration
REQ-030 SHALL, with macro IBUS_MEM_RESPONDER_ERR_EN defined, answer with iBus_rsp_err=1 and iBus_rsp_inst=0 when pc[1:0] != 0 or pc[31:2] >= DEPTH_WORDS; timing and ordering are unchanged.
REQ-031 SHALL, without IBUS_MEM_RESPONDER_ERR_EN, tie iBus_rsp_err to 0, ignore pc[1:0], and wrap the address modulo DEPTH_WORDS.

Verification
REQ-032 SHALL cover: load word 5 = 0x00500093, then fetch pc=0x14 with LATENCY=1 -> iBus_rsp_ready=1 one cycle later, inst=0x00500093, err=0.
REQ-033 SHALL cover: cmd_valid held high for pc 0x0,0x4,0x8,0xC, with LATENCY=2 and MAX_OUTSTANDING=2 -> four responses on consecutive cycles starting 2 cycles after the first accept, in order, with cmd_ready never low.
REQ-034 SHALL cover: LATENCY=4, MAX_OUTSTANDING=2, continuous valid -> cmd_ready drops after 2 accepts and rises again in each response cycle.
REQ-035 SHALL cover: rstf pulsed one cycle while 2 commands are in flight -> no response strobes afterwards, outstanding=0, cmd_ready=1 the next cycle.
REQ-036 SHALL cover, with ERR_EN defined: pc=0x6 -> err=1, inst=0; pc=DEPTH_WORDS*4 -> err=1. Without ERR_EN, pc=DEPTH_WORDS*4 -> word 0, err=0.
REQ-037 SHALL cover: in the same cycle, ld_en to word 3 = 0xDEADBEEF and fetch pc=0xC -> old data returned; a refetch of pc=0xC returns 0xDEADBEEF.
